// File: rtl/ps2_rx_if.sv
// Read-side bus of the PS/2 receiver: head byte, valid and consumer ready.
interface ps2_rx_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and de-glitches the PS/2 clock,
// decodes 11-bit frames and queues good bytes in a small FIFO.
module ps2_rx #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 4096,
    parameter int FIFO_AW    = 2
) (
    input  logic     clk_core,
    input  logic     core_reset_n,
    input  logic     ps2_clk,
    input  logic     ps2_data,
    ps2_rx_if.master rd,
    output logic     inhibit,
    output logic     frame_err,
    output logic     overrun,
    input  logic     clr_err
);

    localparam int FCW   = $clog2(FILTER_LEN + 1);
    localparam int TCW   = $clog2(TIMEOUT + 1);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Frame is accepted when the stop bit is 1 and data plus parity has odd weight.
    function automatic logic frame_ok(input logic [7:0] d, input logic p, input logic s);
        return s & (^{d, p});
    endfunction

    logic [1:0]         clk_sync_r;
    logic [1:0]         data_sync_r;
    logic               filt_r;
    logic               filt_d_r;
    logic [FCW-1:0]     filt_cnt_r;
    logic               clk_s;
    logic               data_s;
    logic               strobe_s;

    state_t             state_r;
    state_t             state_n;
    logic [2:0]         bit_cnt_r;
    logic [7:0]         shift_r;
    logic               par_r;
    logic [TCW-1:0]     to_cnt_r;
    logic               timeout_s;
    logic               good_s;
    logic               err_s;
    logic               push_r;

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_n;
    logic               rd_valid_r;
    logic               inhibit_r;
    logic               frame_err_r;
    logic               overrun_r;
    logic               full_s;
    logic               pop_s;
    logic               wr_s;
    logic               drop_s;

    assign clk_s     = clk_sync_r[1];
    assign data_s    = data_sync_r[1];
    assign strobe_s  = filt_d_r & ~filt_r;
    assign timeout_s = (state_r != IDLE) && (to_cnt_r == TCW'(TIMEOUT));

    // Two-flop synchronizers for the asynchronous pad inputs.
    always_ff @(posedge clk_core or negedge core_reset_n) begin
        if (!core_reset_n) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    // Glitch filter: the new level must persist FILTER_LEN samples to be taken.
    always_ff @(posedge clk_core or negedge core_reset_n) begin
        if (!core_reset_n) begin
            filt_r     <= 1'b1;
            filt_d_r   <= 1'b1;
            filt_cnt_r <= '0;
        end else begin
            filt_d_r <= filt_r;
            if (clk_s == filt_r) begin
                filt_cnt_r <= '0;
            end else if (filt_cnt_r == FCW'(FILTER_LEN - 1)) begin
                filt_r     <= clk_s;
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + FCW'(1);
            end
        end
    end

    // Frame decoder state register.
    always_ff @(posedge clk_core or negedge core_reset_n) begin
        if (!core_reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Frame decoder next state; a timeout overrides any strobe in the same cycle.
    always_comb begin
        state_n = state_r;
        good_s  = 1'b0;
        err_s   = 1'b0;
        if (timeout_s) begin
            state_n = IDLE;
            err_s   = 1'b1;
        end else if (strobe_s) begin
            case (state_r)
                IDLE: begin
                    if (!data_s) begin
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end
                DATA: begin
                    if (bit_cnt_r == 3'd7) begin
                        state_n = PARITY;
                    end else begin
                        state_n = DATA;
                    end
                end
                PARITY: state_n = STOP;
                STOP: begin
                    state_n = IDLE;
                    if (frame_ok(shift_r, par_r, data_s)) begin
                        good_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Bit collection, timeout counting and the delayed push request.
    always_ff @(posedge clk_core or negedge core_reset_n) begin
        if (!core_reset_n) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            par_r     <= 1'b0;
            to_cnt_r  <= '0;
            push_r    <= 1'b0;
        end else begin
            push_r <= good_s;
            if (strobe_s || (state_r == IDLE)) begin
                to_cnt_r <= '0;
            end else if (to_cnt_r != TCW'(TIMEOUT)) begin
                to_cnt_r <= to_cnt_r + TCW'(1);
            end
            if (state_r == IDLE) begin
                bit_cnt_r <= 3'd0;
            end else if (strobe_s && (state_r == DATA)) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
                shift_r   <= {data_s, shift_r[7:1]};
            end
            if (strobe_s && (state_r == PARITY)) begin
                par_r <= data_s;
            end
        end
    end

    assign full_s = (cnt_r == CW'(DEPTH));
    assign pop_s  = rd_valid_r & rd.rd_ready;
    assign wr_s   = push_r & (~full_s | pop_s);
    assign drop_s = push_r & full_s & ~pop_s;

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        cnt_n = cnt_r;
        case ({wr_s, pop_s})
            2'b10:   cnt_n = cnt_r + CW'(1);
            2'b01:   cnt_n = cnt_r - CW'(1);
            default: cnt_n = cnt_r;
        endcase
    end

    // FIFO storage; cleared on reset so the head reads 0x00 out of reset.
    always_ff @(posedge clk_core or negedge core_reset_n) begin
        if (!core_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (wr_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers, occupancy and registered status flags.
    always_ff @(posedge clk_core or negedge core_reset_n) begin
        if (!core_reset_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            cnt_r       <= '0;
            rd_valid_r  <= 1'b0;
            inhibit_r   <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
            end
            cnt_r      <= cnt_n;
            rd_valid_r <= (cnt_n != CW'(0));
            inhibit_r  <= (cnt_n == CW'(DEPTH));
            if (err_s) begin
                frame_err_r <= 1'b1;
            end else if (clr_err) begin
                frame_err_r <= 1'b0;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (clr_err) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign rd.rd_data  = mem_r[rd_ptr_r];
    assign rd.rd_valid = rd_valid_r;
    assign inhibit     = inhibit_r;
    assign frame_err   = frame_err_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed scenarios plus randomized frames
// compared against a byte-queue model of the receiver.
module tb_ps2_rx;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 4096;

    logic clk_core     = 1'b0;
    logic core_reset_n = 1'b0;
    logic ps2_clk      = 1'b1;
    logic ps2_data     = 1'b1;
    logic clr_err      = 1'b0;
    logic inhibit;
    logic frame_err;
    logic overrun;

    ps2_rx_if rd_if ();

    ps2_rx dut (
        .clk_core     (clk_core),
        .core_reset_n (core_reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rd           (rd_if),
        .inhibit      (inhibit),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .clr_err      (clr_err)
    );

    always #5 clk_core = ~clk_core;

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [7:0] m_q[$];
    logic       m_err = 1'b0;
    logic       m_ovr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_core);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(20);
        ps2_clk = 1'b1;
        wait_cyc(10);
    endtask

    // Sends a full frame and applies the receiver rules to the model.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^d) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(p);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        wait_cyc(20);
        if (!bad_par && !bad_stop) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovr = 1'b1;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".valid"}, rd_if.rd_valid, (m_q.size() != 0));
        if (m_q.size() != 0) check_eq({tag, ".data"}, rd_if.rd_data, m_q[0]);
        check_eq({tag, ".inhibit"}, inhibit, (m_q.size() == DEPTH));
        check_eq({tag, ".frame_err"}, frame_err, m_err);
        check_eq({tag, ".overrun"}, overrun, m_ovr);
    endtask

    task automatic do_read();
        rd_if.rd_ready = 1'b1;
        wait_cyc(1);
        rd_if.rd_ready = 1'b0;
        if (m_q.size() != 0) void'(m_q.pop_front());
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        m_err = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".valid"}, rd_if.rd_valid, 1'b0);
        check_eq({tag, ".data"}, rd_if.rd_data, 8'h00);
        check_eq({tag, ".inhibit"}, inhibit, 1'b0);
        check_eq({tag, ".frame_err"}, frame_err, 1'b0);
        check_eq({tag, ".overrun"}, overrun, 1'b0);
    endtask

    initial begin
        rd_if.rd_ready = 1'b0;
        wait_cyc(3);
        check_reset_vals("reset");
        core_reset_n = 1'b1;
        wait_cyc(5);

        // Good frame, then read it out; a read on empty changes nothing.
        send_frame(8'h1C, 1'b0, 1'b0);
        check_all("f1c");
        check_eq("f1c.const", rd_if.rd_data, 8'h1C);
        do_read();
        check_all("f1c_pop");
        do_read();
        check_all("empty_rd");

        // Wrong parity is rejected and flagged until cleared.
        send_frame(8'h1C, 1'b1, 1'b0);
        check_all("badpar");
        check_eq("badpar.const", frame_err, 1'b1);
        do_clr();
        check_all("badpar_clr");

        // A short low pulse with data low must not start a frame.
        ps2_data = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        wait_cyc(20);
        ps2_data = 1'b1;
        wait_cyc(5);
        check_all("glitch");
        send_frame(8'h3A, 1'b0, 1'b0);
        check_all("post_glitch");
        do_read();

        // Fill past capacity with no reads, then drain.
        for (int v = 1; v <= 5; v++) begin
            send_frame(8'(v), 1'b0, 1'b0);
            check_all("fill");
        end
        check_eq("fill.inhibit", inhibit, 1'b1);
        check_eq("fill.overrun", overrun, 1'b1);
        for (int v = 1; v <= 4; v++) begin
            check_eq("drain", rd_if.rd_data, 32'(v));
            do_read();
            check_all("drain_st");
        end
        do_clr();

        // Partial frame abandoned by the timeout, then a clean frame.
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        wait_cyc(TIMEOUT + 100);
        m_err = 1'b1;
        check_all("timeout");
        do_clr();
        send_frame(8'hAA, 1'b0, 1'b0);
        check_all("after_to");
        do_read();

        // Reset mid-frame with a byte queued, then a clean frame.
        send_frame(8'h77, 1'b0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
        core_reset_n = 1'b0;
        wait_cyc(3);
        check_reset_vals("midrst");
        m_q.delete();
        m_err = 1'b0;
        m_ovr = 1'b0;
        ps2_data = 1'b1;
        core_reset_n = 1'b1;
        wait_cyc(5);
        send_frame(8'h55, 1'b0, 1'b0);
        check_all("after_rst");
        check_eq("after_rst.const", rd_if.rd_data, 8'h55);
        do_read();

        // Randomized frames, errors, reads and clears.
        for (int it = 0; it < 30; it++) begin
            logic [7:0] d;
            int         k;
            d = 8'($urandom);
            k = $urandom_range(0, 7);
            send_frame(d, (k == 0), (k == 1));
            check_all("rnd");
            if ($urandom_range(0, 2) != 0) begin
                do_read();
                check_all("rnd_rd");
            end
            if ($urandom_range(0, 4) == 0) begin
                do_clr();
                check_all("rnd_clr");
            end
        end
        while (m_q.size() != 0) begin
            do_read();
            check_all("final_drain");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
